note_sequencer: RTL and testbench

Playback controller for the score position counter. Steps a note array one entry at a time, holds each note for its duration in beat ticks, then advances the external position counter through its enable and reset. Sits between the tempo tick generator, the position counter and the synchronous note-duration ROM addressed by `pos`. Provides play, pause, stop and optional looping.

---
 rtl/note_sequencer.sv | 156 +++++++++++++++
 tb/tb_note_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: steps a note-duration array through an external position
// counter, holding each note for its duration in beat ticks, with play,
// pause, stop and optional looping.
// Build option: define NOTE_SEQ_LOOP_EN to honour i_loop; when undefined,
// i_loop is ignored and playback always ends after the last note.
module note_sequencer #(
    parameter int unsigned POS_BITS   = 4,
    parameter int unsigned ARRAY_SIZE = 16,
    parameter int unsigned DUR_BITS   = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_play,
    input  logic                i_pause,
    input  logic                i_stop,
    input  logic                i_loop,
    input  logic                i_beat,
    input  logic [POS_BITS-1:0] i_pos,
    input  logic [DUR_BITS-1:0] i_note_dur,
    output logic                o_pos_en,
    output logic                o_pos_rst,
    output logic                o_note_start,
    output logic                o_done,
    output logic                o_playing,
    output logic                o_paused,
    output logic [DUR_BITS-1:0] o_remaining
);

    localparam logic [POS_BITS-1:0] LAST_POS = POS_BITS'(ARRAY_SIZE - 1);
    localparam logic [DUR_BITS-1:0] DUR_ONE  = DUR_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_PLAY   = 3'd3,
        S_PAUSED = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DUR_BITS-1:0] r_remaining;
    logic [DUR_BITS-1:0] w_remaining_next;
    logic                r_note_start;
    logic                r_done;
    logic                r_playing;
    logic                r_paused;
    logic                w_loop;
    logic                w_last;

`ifdef NOTE_SEQ_LOOP_EN
    assign w_loop = i_loop;
`else
    // Looping compiled out: the port stays for a fixed pinout but is inert.
    logic w_unused_loop;
    assign w_unused_loop = i_loop;
    assign w_loop        = 1'b0;
`endif

    assign w_last = (i_pos == LAST_POS);

    // Next-state, beat countdown and position-counter strobes.
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        o_pos_en         = 1'b0;
        o_pos_rst        = 1'b0;

        case (r_state)
            S_IDLE: begin
                o_pos_rst = 1'b1;
                if (i_play) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                // A zero-length note still lasts one beat.
                w_remaining_next = (i_note_dur == '0) ? DUR_ONE : i_note_dur;
                w_state_next     = S_PLAY;
            end
            S_PLAY: begin
                if (i_pause) begin
                    w_state_next = S_PAUSED;
                end else if (i_beat) begin
                    if (r_remaining > DUR_ONE) begin
                        w_remaining_next = r_remaining - DUR_ONE;
                    end else begin
                        w_remaining_next = '0;
                        if (!w_last || w_loop) begin
                            o_pos_en     = 1'b1;
                            w_state_next = S_FETCH;
                        end else begin
                            w_state_next = S_DONE;
                        end
                    end
                end
            end
            S_PAUSED: begin
                if (i_play && !i_pause) begin
                    w_state_next = S_PLAY;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Stop and reset override everything; no advance strobe with them.
        if (i_stop || i_rst) begin
            w_state_next     = S_IDLE;
            w_remaining_next = '0;
            o_pos_en         = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
        end
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_note_start <= 1'b0;
            r_done       <= 1'b0;
            r_playing    <= 1'b0;
            r_paused     <= 1'b0;
        end else begin
            r_note_start <= (w_state_next == S_LOAD);
            r_done       <= (w_state_next == S_DONE);
            r_playing    <= (w_state_next == S_FETCH) || (w_state_next == S_LOAD) ||
                            (w_state_next == S_PLAY);
            r_paused     <= (w_state_next == S_PAUSED);
        end
    end

    assign o_note_start = r_note_start;
    assign o_done       = r_done;
    assign o_playing    = r_playing;
    assign o_paused     = r_paused;
    assign o_remaining  = r_remaining;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: position counter and note ROM models, a per-cycle
// vector table for pause/stop/reset corners, and scoreboarded playback runs.
module tb_note_sequencer;

    logic       clk;
    logic       rst, play, pause, stop, loop, beat;
    logic [1:0] pos;
    logic [3:0] note_dur;
    logic       pos_en, pos_rst, note_start, done, playing, paused;
    logic [3:0] remaining;

    int n_checks = 0;
    int n_pass   = 0;
    int beats_seen  = 0;
    int total_beats = 0;
    bit sb_en = 1'b0;

    typedef struct {
        logic       is_done;
        logic [1:0] pos;
        int         beats;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        int rst, play, pause, stop, beat;
        int pe, pl, pa, ns, dn, pr, rem, cp, pos;
    } vec_t;
    vec_t tbl[33];

    note_sequencer #(.POS_BITS(2), .ARRAY_SIZE(4), .DUR_BITS(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_play(play), .i_pause(pause), .i_stop(stop),
        .i_loop(loop), .i_beat(beat), .i_pos(pos), .i_note_dur(note_dur),
        .o_pos_en(pos_en), .o_pos_rst(pos_rst), .o_note_start(note_start),
        .o_done(done), .o_playing(playing), .o_paused(paused), .o_remaining(remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] dur_of(input logic [1:0] p);
        case (p)
            2'd0:    return 4'd2;
            2'd1:    return 4'd1;
            2'd2:    return 4'd3;
            default: return 4'd0;
        endcase
    endfunction

    // Position counter and synchronous note ROM models.
    always_ff @(posedge clk) begin
        if (pos_rst)     pos <= 2'd0;
        else if (pos_en) pos <= pos + 2'd1;
        note_dur <= dur_of(pos);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Per-cycle observer: strobe exclusivity, beat counting, event scoreboard.
    task automatic monitor();
        ev_t e;
        chk("pos_en_pos_rst_exclusive", int'(pos_en & pos_rst), 0);
        if (sb_en) begin
            if (beat && playing && !note_start && !pause && !stop) begin
                beats_seen++;
                total_beats++;
            end
            if (note_start || done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event_queue_size", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("event_is_done", int'(done), int'(e.is_done));
                    if (!e.is_done) chk("note_start_pos", int'(pos), int'(e.pos));
                    chk("beats_in_note", beats_seen, e.beats);
                end
                beats_seen = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(input int i_rst, i_play, i_pause, i_stop, i_beat,
                               e_pe, e_pl, e_pa, e_ns, e_dn, e_pr, e_rem, e_cp, e_pos);
        vec_t r;
        r.rst = i_rst; r.play = i_play; r.pause = i_pause; r.stop = i_stop; r.beat = i_beat;
        r.pe = e_pe; r.pl = e_pl; r.pa = e_pa; r.ns = e_ns; r.dn = e_dn; r.pr = e_pr;
        r.rem = e_rem; r.cp = e_cp; r.pos = e_pos;
        return r;
    endfunction

    function automatic ev_t ev(input logic d, input logic [1:0] p, input int b);
        ev_t e;
        e.is_done = d; e.pos = p; e.beats = b;
        return e;
    endfunction

    task automatic run_seq(input logic lp, input int budget);
        int k;
        k = 0;
        loop = lp;
        beats_seen = 0;
        sb_en = 1'b1;
        while (sb.size() > 0 && k < budget) begin
            play = (k == 0);
            beat = ((k % 4) == 3);
            tick();
            k++;
        end
        play = 1'b0;
        beat = 1'b0;
        chk("sequence_finished_in_budget", sb.size(), 0);
        sb_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0; loop = 1'b0; beat = 1'b0;

        //            rst pl pa st bt | pe pl pa ns dn pr rem cp pos
        tbl[0]  = v(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[1]  = v(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[2]  = v(0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[3]  = v(0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0, 1, 0);
        tbl[4]  = v(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 2, 1, 0);
        tbl[5]  = v(0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 0, 1, 1, 0);
        tbl[6]  = v(0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0, 1, 1);
        tbl[7]  = v(0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0, 1, 1);
        tbl[8]  = v(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 1, 1);
        tbl[9]  = v(0, 0, 1, 0, 1,   0, 0, 1, 0, 0, 0, 1, 1, 1);
        tbl[10] = v(0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 1, 1, 1);
        tbl[11] = v(0, 1, 1, 0, 0,   0, 0, 1, 0, 0, 0, 1, 1, 1);
        tbl[12] = v(0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 1, 1);
        tbl[13] = v(0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0, 1, 2);
        tbl[14] = v(0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0, 1, 2);
        tbl[15] = v(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 3, 1, 2);
        tbl[16] = v(0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 0, 2, 1, 2);
        tbl[17] = v(0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 2, 1, 2);
        for (int i = 18; i < 23; i++) tbl[i] = v(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2, 1, 2);
        tbl[23] = v(0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 2, 1, 2);
        tbl[24] = v(0, 1, 0, 0, 1,   0, 1, 0, 0, 0, 0, 1, 1, 2);
        tbl[25] = v(0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1, 0, 1, 2);
        tbl[26] = v(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[27] = v(0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[28] = v(0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0, 1, 0);
        tbl[29] = v(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[30] = v(0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[31] = v(0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0, 1, 0);
        tbl[32] = v(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 2, 1, 0);

        @(posedge clk);
        #1;

        // Vector table: inputs for one edge, strobe before it, state after it.
        for (int i = 0; i < 33; i++) begin
            rst   = 1'(tbl[i].rst);
            play  = 1'(tbl[i].play);
            pause = 1'(tbl[i].pause);
            stop  = 1'(tbl[i].stop);
            beat  = 1'(tbl[i].beat);
            #1;
            chk($sformatf("row%0d_pos_en", i), int'(pos_en), tbl[i].pe);
            tick();
            chk($sformatf("row%0d_playing", i), int'(playing), tbl[i].pl);
            chk($sformatf("row%0d_paused", i), int'(paused), tbl[i].pa);
            chk($sformatf("row%0d_note_start", i), int'(note_start), tbl[i].ns);
            chk($sformatf("row%0d_done", i), int'(done), tbl[i].dn);
            chk($sformatf("row%0d_pos_rst", i), int'(pos_rst), tbl[i].pr);
            chk($sformatf("row%0d_remaining", i), int'(remaining), tbl[i].rem);
            if (tbl[i].cp != 0) chk($sformatf("row%0d_pos", i), int'(pos), tbl[i].pos);
        end
        rst = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; beat = 1'b0;

        // Return to IDLE with the counter at 0.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("idle_before_seq_pos", int'(pos), 0);

        // Full playback without looping.
        total_beats = 0;
        sb.push_back(ev(1'b0, 2'd0, 0));
        sb.push_back(ev(1'b0, 2'd1, 2));
        sb.push_back(ev(1'b0, 2'd2, 1));
        sb.push_back(ev(1'b0, 2'd3, 3));
        sb.push_back(ev(1'b1, 2'd0, 1));
        run_seq(1'b0, 200);
        chk("total_beats_no_loop", total_beats, 7);
        chk("after_done_pos_rst", int'(pos_rst), 1);
        chk("after_done_done_low", int'(done), 0);
        tick();
        chk("after_done_pos_zero", int'(pos), 0);

        // Playback with loop requested.
        sb.push_back(ev(1'b0, 2'd0, 0));
        sb.push_back(ev(1'b0, 2'd1, 2));
        sb.push_back(ev(1'b0, 2'd2, 1));
        sb.push_back(ev(1'b0, 2'd3, 3));
`ifdef NOTE_SEQ_LOOP_EN
        sb.push_back(ev(1'b0, 2'd0, 1));
`else
        sb.push_back(ev(1'b1, 2'd0, 1));
`endif
        run_seq(1'b1, 200);
        loop = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("after_stop_playing", int'(playing), 0);
        chk("after_stop_remaining", int'(remaining), 0);
        for (int i = 0; i < 6; i++) begin
            beat = (i == 2);
            tick();
            chk("no_done_after_stop", int'(done), 0);
        end
        beat = 1'b0;
        chk("after_stop_pos_zero", int'(pos), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
